// File: rtl/replay_queue.sv
// replay_queue -- circular FIFO with commit/rewind replay.
//
// Entries that have been dequeued stay in storage until they are committed.
// Asserting recover moves the read pointer back to the last commit point, so
// the consumer can re-read an aborted transaction without any backup copy.
//
// Optional feature macro: QUEUE_ERR_FLAGS_EN
//   When defined, two sticky error outputs are added. overflow records an
//   enqueue while full. underflow records a dequeue while empty with recover
//   low. Both flags clear only on reset. When the macro is undefined, these
//   ports do not exist and rejected requests are silent.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   enqueue      write request (accepted when not full)
//   dequeue      read request (accepted when not empty and recover low)
//   commit       free every entry read so far, including a same-cycle read
//   recover      rewind the read pointer to the last commit point
//   Din          write data
//   Dout         registered read data; holds its value between reads
//   Dout_valid   one-cycle pulse when Dout was updated by an accepted read
//   full         occupancy == DEPTH
//   almost_full  occupancy >= AFULL_LEVEL
//   empty        no unread entries
//   count        occupancy: held plus unread entries (wr - cm)
//   pending      entries read but not yet committed (rd - cm)
//   overflow     sticky enqueue-while-full flag (QUEUE_ERR_FLAGS_EN only)
//   underflow    sticky dequeue-while-empty flag (QUEUE_ERR_FLAGS_EN only)

module replay_queue #(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 256,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enqueue,
    input  logic                     dequeue,
    input  logic                     commit,
    input  logic                     recover,
    input  logic [WIDTH-1:0]         Din,
    output logic [WIDTH-1:0]         Dout,
    output logic                     Dout_valid,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pending
`ifdef QUEUE_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);
    localparam logic [PW:0] AFULL_V = (PW+1)'(AFULL_LEVEL);
    localparam logic [PW:0] ONE_V   = (PW+1)'(1);

    // Pointers carry one extra wrap bit, so equal addresses are told apart as
    // full (wrap bits differ) or empty (wrap bits equal).
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cm_ptr_q, cm_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW:0]      count_s;
    logic [PW:0]      pending_s;
    logic [PW:0]      readable_s;
    logic             full_s;
    logic             empty_s;
    logic             enq_ok_s;
    logic             deq_ok_s;

    // Status is decoded from registered pointers, so it follows each accepted
    // operation by exactly one edge.
    always_comb begin
        count_s    = wr_ptr_q - cm_ptr_q;
        pending_s  = rd_ptr_q - cm_ptr_q;
        readable_s = wr_ptr_q - rd_ptr_q;
        full_s     = (count_s == DEPTH_V);
        empty_s    = (readable_s == {(PW+1){1'b0}});
        enq_ok_s   = enqueue && !full_s;
        // A read never frees space and never bypasses an empty queue; recover
        // wins over a same-cycle read.
        deq_ok_s   = dequeue && !empty_s && !recover;
    end

    // Next-state pointers and read data. Priority: recover > commit > dequeue.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        if (enq_ok_s) begin
            wr_ptr_d = wr_ptr_q + ONE_V;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (recover) begin
            rd_ptr_d = cm_ptr_q;
        end else if (deq_ok_s) begin
            rd_ptr_d     = rd_ptr_q + ONE_V;
            dout_d       = mem[rd_ptr_q[PW-1:0]];
            dout_valid_d = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Commit uses the updated read pointer, so a read in the same cycle
        // is committed along with the earlier ones.
        if (!recover && commit) begin
            cm_ptr_d = rd_ptr_d;
        end else begin
            cm_ptr_d = cm_ptr_q;
        end
    end

    // Pointer and output registers; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= {(PW+1){1'b0}};
            rd_ptr_q     <= {(PW+1){1'b0}};
            cm_ptr_q     <= {(PW+1){1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage array; reset does not clear it.
    always_ff @(posedge clk) begin
        if (enq_ok_s) begin
            mem[wr_ptr_q[PW-1:0]] <= Din;
        end
    end

`ifdef QUEUE_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags are set by rejected requests and cleared only by reset.
    always_comb begin
        overflow_d  = overflow_q  | (enqueue && full_s);
        underflow_d = underflow_q | (dequeue && empty_s && !recover);
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign Dout        = dout_q;
    assign Dout_valid  = dout_valid_q;
    assign full        = full_s;
    assign almost_full = (count_s >= AFULL_V);
    assign empty       = empty_s;
    assign count       = count_s;
    assign pending     = pending_s;

endmodule
